// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the four-slot TDM demultiplexer.
package tdm_pkg;

    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned SLOT_W    = 2;
    localparam int unsigned MISS_W    = 4;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM demultiplexer: increments per accepted sample,
// can be forced to 1 on resync or cleared on lock loss.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load1,
    input  logic              inc,
    output logic [SLOT_W-1:0] slot,
    output logic              last
);

    logic [SLOT_W-1:0] slot_d;
    logic [SLOT_W-1:0] slot_q;

    always_comb begin
        slot_d = slot_q;
        if (clr) begin
            slot_d = '0;
        end else if (load1) begin
            slot_d = SLOT_W'(1);
        end else if (inc) begin
            slot_d = slot_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot = slot_q;
    assign last = (slot_q == SLOT_W'(NUM_SLOTS - 1));

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: aligns to the slot-0 sync marker, rebuilds each
// frame in a shadow buffer and publishes complete frames with a valid strobe.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned MAX_MISS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             sync,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err,
    output logic [1:0]       slot
);

    tdm_state_e        state_d, state_q;
    logic [WIDTH-1:0]  shadow_d [NUM_SLOTS-1];
    logic [WIDTH-1:0]  shadow_q [NUM_SLOTS-1];
    logic [WIDTH-1:0]  ch_d     [NUM_SLOTS];
    logic [WIDTH-1:0]  ch_q     [NUM_SLOTS];
    logic [MISS_W-1:0] miss_d, miss_q;
    logic [MISS_W-1:0] miss_inc;
    logic              frame_valid_d, frame_valid_q;
    logic              sync_err_d, sync_err_q;
    logic              ctr_clr, ctr_load1, ctr_inc, ctr_last;
    logic [SLOT_W-1:0] cur_slot;

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ctr_clr),
        .load1 (ctr_load1),
        .inc   (ctr_inc),
        .slot  (cur_slot),
        .last  (ctr_last)
    );

    assign miss_inc = miss_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        ch_d          = ch_q;
        miss_d        = miss_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        ctr_clr       = 1'b0;
        ctr_load1     = 1'b0;
        ctr_inc       = 1'b0;

        if (en) begin
            unique case (state_q)
                HUNT: begin
                    if (sync) begin
                        shadow_d[0] = din;
                        ctr_load1   = 1'b1;
                        miss_d      = '0;
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (cur_slot == '0) begin
                        if (sync) begin
                            shadow_d[0] = din;
                            ctr_inc     = 1'b1;
                            miss_d      = '0;
                        end else if (miss_inc >= MISS_W'(MAX_MISS)) begin
                            // Flywheel exhausted: this sample is dropped, not kept as slot 0.
                            state_d    = HUNT;
                            ctr_clr    = 1'b1;
                            miss_d     = '0;
                            sync_err_d = 1'b1;
                        end else begin
                            shadow_d[0] = din;
                            ctr_inc     = 1'b1;
                            miss_d      = miss_inc;
                        end
                    end else if (sync) begin
                        shadow_d[0] = din;
                        ctr_load1   = 1'b1;
                        miss_d      = '0;
                        sync_err_d  = 1'b1;
                    end else if (ctr_last) begin
                        for (int unsigned i = 0; i < NUM_SLOTS - 1; i++) begin
                            ch_d[i] = shadow_q[i];
                        end
                        ch_d[NUM_SLOTS-1] = din;
                        frame_valid_d     = 1'b1;
                        ctr_inc           = 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < NUM_SLOTS - 1; i++) begin
                            if (cur_slot == SLOT_W'(i)) begin
                                shadow_d[i] = din;
                            end
                        end
                        ctr_inc = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            shadow_q      <= '{default: '0};
            ch_q          <= '{default: '0};
            miss_q        <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            ch_q          <= ch_d;
            miss_q        <= miss_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign ch0         = ch_q[0];
    assign ch1         = ch_q[1];
    assign ch2         = ch_q[2];
    assign ch3         = ch_q[3];
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign locked      = (state_q == LOCKED);
    assign slot        = cur_slot;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4 (WIDTH=1, MAX_MISS=2).
module tb_tdm_demux4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [0:0] din;
    logic       sync;
    logic [0:0] ch0, ch1, ch2, ch3;
    logic       frame_valid;
    logic       locked;
    logic       sync_err;
    logic [1:0] slot;

    int n_chk  = 0;
    int n_pass = 0;

    tdm_demux4 #(
        .WIDTH    (1),
        .MAX_MISS (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .din         (din),
        .sync        (sync),
        .ch0         (ch0),
        .ch1         (ch1),
        .ch2         (ch2),
        .ch3         (ch3),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err),
        .slot        (slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] chs();
        return {ch3, ch2, ch1, ch0};
    endfunction

    // Drive on the falling edge, return 1 time unit after the sampling edge.
    task automatic step(input logic e, input logic d, input logic s);
        @(negedge clk);
        en   = e;
        din  = d;
        sync = s;
        @(posedge clk);
        #1;
    endtask

    // d = {slot3, slot2, slot1, slot0}; a delivered frame reads back as d.
    task automatic send_frame(input string tag, input logic [3:0] d, input logic s0,
                              input logic exp_fv);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, d[i], (i == 0) ? s0 : 1'b0);
            chk({tag, "_serr"}, 32'(sync_err), 32'd0);
            if (i < 3) begin
                chk({tag, "_fv_mid"}, 32'(frame_valid), 32'd0);
            end else begin
                chk({tag, "_fv_end"}, 32'(frame_valid), 32'(exp_fv));
                if (exp_fv) chk({tag, "_ch"}, 32'(chs()), 32'(d));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        din   = '0;
        sync  = 1'b0;
        #12;
        chk("rst_ch", 32'(chs()), 32'h0);
        chk("rst_fv", 32'(frame_valid), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_serr", 32'(sync_err), 32'd0);
        chk("rst_slot", 32'(slot), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // HUNT: samples without sync are ignored
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'(i & 1) ^ 1'b1, 1'b0);
            chk("hunt_fv", 32'(frame_valid), 32'd0);
            chk("hunt_slot", 32'(slot), 32'd0);
        end
        chk("hunt_locked", 32'(locked), 32'd0);
        chk("hunt_ch", 32'(chs()), 32'h0);

        // Nominal: 0,1,0,1 then 1,1,0,0
        step(1'b1, 1'b0, 1'b1);
        chk("nom_locked", 32'(locked), 32'd1);
        chk("nom_slot1", 32'(slot), 32'd1);
        step(1'b1, 1'b1, 1'b0);
        chk("nom_fv1", 32'(frame_valid), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("nom_fv2", 32'(frame_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        chk("nom_fv3", 32'(frame_valid), 32'd1);
        chk("nom_ch_a", 32'(chs()), 32'hA);
        chk("nom_slot0", 32'(slot), 32'd0);
        send_frame("nom_b", 4'b0011, 1'b1, 1'b1);

        // Misplaced sync at slot 2: A=1(sync) B=0 C=0(sync) D=1 E=1 F=0
        step(1'b1, 1'b1, 1'b1);
        chk("mis_fv_a", 32'(frame_valid), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("mis_serr", 32'(sync_err), 32'd1);
        chk("mis_slot", 32'(slot), 32'd1);
        chk("mis_locked", 32'(locked), 32'd1);
        chk("mis_ch_hold", 32'(chs()), 32'h3);
        step(1'b1, 1'b1, 1'b0);
        chk("mis_serr_off", 32'(sync_err), 32'd0);
        chk("mis_fv_d", 32'(frame_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        chk("mis_fv_e", 32'(frame_valid), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("mis_fv_f", 32'(frame_valid), 32'd1);
        chk("mis_ch", 32'(chs()), 32'h6);

        // Flywheel: one miss tolerated, second consecutive miss drops lock
        send_frame("fly1", 4'b1001, 1'b0, 1'b1);
        chk("fly1_locked", 32'(locked), 32'd1);
        send_frame("fly_sync", 4'b1110, 1'b1, 1'b1);
        send_frame("fly2", 4'b1100, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("loss_serr", 32'(sync_err), 32'd1);
        chk("loss_locked", 32'(locked), 32'd0);
        chk("loss_slot", 32'(slot), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("loss_fv", 32'(frame_valid), 32'd0);
            chk("loss_serr_off", 32'(sync_err), 32'd0);
        end
        chk("loss_ch_hold", 32'(chs()), 32'hC);

        // Gapped en, sync during idle cycles must be ignored
        for (int i = 0; i < 4; i++) begin
            logic [3:0] gd;
            gd = 4'b1101;
            step(1'b1, gd[i], (i == 0));
            chk("gap_fv_act", 32'(frame_valid), (i == 3) ? 32'd1 : 32'd0);
            if (i == 3) chk("gap_ch", 32'(chs()), 32'hD);
            step(1'b0, ~gd[i], 1'b1);
            chk("gap_fv_idle", 32'(frame_valid), 32'd0);
            chk("gap_serr_idle", 32'(sync_err), 32'd0);
            chk("gap_slot", 32'(slot), 32'((i + 1) % 4));
        end

        // Async reset mid-frame, then fresh sync
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ch", 32'(chs()), 32'h0);
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_slot", 32'(slot), 32'd0);
        chk("arst_fv", 32'(frame_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame("post_rst", 4'b1101, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("post_rst_fv_off", 32'(frame_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
